// File: rtl/opcode_pkg.sv
// Shared opcode layout for the encoder and the downstream splitter.
// Both ends import this package, so a field change updates them together.
package opcode_pkg;

    localparam int OPCODE_W  = 96;
    localparam int SHAPE_W   = 4;
    localparam int COLOR_W   = 16;
    localparam int OPDATA_W  = 76;
    localparam int BEAT_W    = 32;
    localparam int NUM_BEATS = 3;

    localparam int SHAPE_MSB  = 95;
    localparam int SHAPE_LSB  = 92;
    localparam int COLOR_MSB  = 91;
    localparam int COLOR_LSB  = 76;
    localparam int OPDATA_MSB = 75;
    localparam int OPDATA_LSB = 0;

    typedef struct packed {
        logic [SHAPE_W-1:0]  shape;
        logic [COLOR_W-1:0]  color;
        logic [OPDATA_W-1:0] opdata;
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        BEAT2 = 2'd3
    } enc_state_t;

endpackage

// File: rtl/opcode_fifo.sv
// Synchronous FIFO with registered occupancy count and async active-low reset.
// Head data is read combinationally so the consumer can load it on the pop edge.
module opcode_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Requests against a full or empty FIFO are ignored, never corrupting count.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/opcode_encoder.sv
// Packs draw commands into 96-bit opcodes, queues them, and streams each
// opcode as three 32-bit beats, most-significant word first.
module opcode_encoder
    import opcode_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [3:0]  MAX_SHAPE  = 4'd7
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SHAPE_W-1:0]            shape,
    input  logic [COLOR_W-1:0]            color,
    input  logic [OPDATA_W-1:0]           opdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BEAT_W-1:0]             out_data,
    output logic                          out_first,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_shape
);

    enc_state_t state;
    enc_state_t state_next;
    opcode_t    cmd;
    opcode_t    head;
    opcode_t    hold;
    logic       full;
    logic       empty;
    logic       accept;
    logic       shape_ok;
    logic       push;
    logic       pop;

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign shape_ok = (shape <= MAX_SHAPE);
    assign push     = accept && shape_ok;
    assign cmd      = '{shape: shape, color: color, opdata: opdata};

    opcode_fifo #(
        .WIDTH (OPCODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push),
        .push_data (cmd),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Finishing BEAT2 pops the next opcode directly so back-to-back opcodes have no bubble.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = BEAT0;
                end
            end
            BEAT0: begin
                if (out_ready) begin
                    state_next = BEAT1;
                end
            end
            BEAT1: begin
                if (out_ready) begin
                    state_next = BEAT2;
                end
            end
            BEAT2: begin
                if (out_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = BEAT0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold      <= '0;
            err_shape <= 1'b0;
        end else begin
            if (pop) begin
                hold <= head;
            end
            err_shape <= accept && !shape_ok;
        end
    end

    // Outputs decode only registered state and the holding register, so they stay stable under backpressure.
    always_comb begin
        out_valid = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state)
            BEAT0: begin
                out_valid = 1'b1;
                out_first = 1'b1;
                out_data  = hold[OPCODE_W-1 -: BEAT_W];
            end
            BEAT1: begin
                out_valid = 1'b1;
                out_data  = hold[OPCODE_W-BEAT_W-1 -: BEAT_W];
            end
            BEAT2: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = hold[BEAT_W-1:0];
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_opcode_encoder.sv
// Directed bench for opcode_encoder: an opcode-queue model checked every cycle,
// plus literal expectations for each scenario.
module tb_opcode_encoder;

    localparam int DEPTH = 4;

    logic        clk;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  shape;
    logic [15:0] color;
    logic [75:0] opdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_first;
    logic        out_last;
    logic [2:0]  fifo_count;
    logic        err_shape;

    opcode_encoder #(.FIFO_DEPTH(DEPTH), .MAX_SHAPE(4'd7)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shape      (shape),
        .color      (color),
        .opdata     (opdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_first  (out_first),
        .out_last   (out_last),
        .fifo_count (fifo_count),
        .err_shape  (err_shape)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of waiting opcodes plus the opcode on the wire and its beats remaining.
    logic [95:0] m_fifo[$];
    logic [95:0] m_cur = '0;
    int          m_left = 0;
    logic        m_err = 1'b0;
    logic        m_rdy;
    logic        m_load;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_fifo.delete();
            m_left = 0;
            m_err  = 1'b0;
        end else begin
            m_rdy  = (m_fifo.size() != DEPTH);
            m_load = 1'b0;
            if (m_left == 0) begin
                m_load = (m_fifo.size() != 0);
            end else if (out_ready) begin
                m_left = m_left - 1;
                if (m_left == 0) m_load = (m_fifo.size() != 0);
            end
            if (m_load) begin
                m_cur  = m_fifo.pop_front();
                m_left = 3;
            end
            m_err = 1'b0;
            if (in_valid && m_rdy) begin
                if (shape <= 4'd7) m_fifo.push_back({shape, color, opdata});
                else m_err = 1'b1;
            end
        end
    end

    // ---------------- compare + beat collector ----------------
    int          cyc = 0;
    int          peak = 0;
    logic [31:0] got_data[$];
    logic        got_first[$];
    logic        got_last[$];
    int          got_cyc[$];
    logic [95:0] sh;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            check("in_ready", in_ready, m_fifo.size() != DEPTH);
            check("fifo_count", fifo_count, m_fifo.size());
            check("err_shape", err_shape, m_err);
            check("out_valid", out_valid, m_left != 0);
            check("out_first", out_first, m_left == 3);
            check("out_last", out_last, m_left == 1);
            if (m_left != 0) begin
                sh = m_cur >> (32 * (m_left - 1));
                check("out_data", out_data, sh[31:0]);
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_first.push_back(out_first);
                got_last.push_back(out_last);
                got_cyc.push_back(cyc);
            end
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [3:0] s, input logic [15:0] c, input logic [75:0] d);
        in_valid = 1'b1;
        shape    = s;
        color    = c;
        opdata   = d;
    endtask

    // Holds the command until an edge where in_ready was high, bounded.
    task automatic send_cmd(input logic [3:0] s, input logic [15:0] c, input logic [75:0] d);
        logic rdy;
        logic done;
        done = 1'b0;
        drive_cmd(s, c, d);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            rdy = in_ready;
            step();
            done = rdy;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    logic [3:0]  t2_shape[4]  = '{4'd1, 4'd3, 4'd5, 4'd7};
    logic [15:0] t2_color[4]  = '{16'h07E0, 16'h001F, 16'hFFFF, 16'h1234};
    logic [75:0] t2_opd[4]    = '{76'hABC_0000_0000_0000_1234, 76'h111_2222_3333_4444_5555,
                                  76'h000_0000_0000_0000_0001, 76'hFFF_FFFF_FFFF_FFFF_FFFF};
    logic [95:0] op;

    initial begin
        n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        shape = '0; color = '0; opdata = '0;

        // Reset state
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_first", out_first, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_err_shape", err_shape, 1'b0);
        check("rst_fifo_count", fifo_count, 3'd0);
        check("rst_in_ready", in_ready, 1'b1);
        #20 n_rst = 1'b1;
        step();

        // 1: single command, latency and beat order
        out_ready = 1'b1;
        drive_cmd(4'h2, 16'hF800, 76'h0001000200030004005);
        @(negedge clk);
        check("t1_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_not_yet_valid", out_valid, 1'b0);
        check("t1_count_one", fifo_count, 3'd1);
        step();
        @(negedge clk);
        check("t1_b0_valid", out_valid, 1'b1);
        check("t1_b0_data", out_data, 32'h2F800000);
        check("t1_b0_first", out_first, 1'b1);
        step();
        @(negedge clk);
        check("t1_b1_data", out_data, 32'h10002000);
        check("t1_b1_flags", {out_first, out_last}, 2'b00);
        step();
        @(negedge clk);
        check("t1_b2_data", out_data, 32'h30004005);
        check("t1_b2_last", out_last, 1'b1);
        step();
        @(negedge clk);
        check("t1_idle", out_valid, 1'b0);
        step();

        // 2: four back-to-back commands
        got_data.delete(); got_first.delete(); got_last.delete(); got_cyc.delete();
        peak = 0;
        for (int k = 0; k < 4; k++) begin
            drive_cmd(t2_shape[k], t2_color[k], t2_opd[k]);
            @(negedge clk);
            step();
        end
        in_valid = 1'b0;
        repeat (16) step();
        check("t2_beat_count", got_data.size(), 12);
        check("t2_peak", peak, 3);
        if (got_data.size() == 12) begin
            check("t2_word0_lit", got_data[0], 32'h107E0ABC);
            check("t2_word2_lit", got_data[2], 32'h00001234);
            for (int i = 0; i < 12; i++) begin
                op = {t2_shape[i/3], t2_color[i/3], t2_opd[i/3]};
                sh = op >> (32 * (2 - i % 3));
                check("t2_data", got_data[i], sh[31:0]);
                check("t2_first", got_first[i], (i % 3) == 0);
                check("t2_last", got_last[i], (i % 3) == 2);
                check("t2_no_bubble", got_cyc[i], got_cyc[0] + i);
            end
        end

        // 3: backpressure in BEAT1, fill FIFO, BEAT2 pop with refused then accepted push
        drive_cmd(4'h4, 16'hABCD, 76'h123_4567_89AB_CDEF_0123);
        @(negedge clk);
        step();
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive_cmd(4'(i), 16'h5A5A ^ 16'(i), 76'(i * 1000 + 7));
            else in_valid = 1'b0;
            @(negedge clk);
            check("t3_hold_valid", out_valid, 1'b1);
            check("t3_hold_data", out_data, 32'h456789AB);
            check("t3_hold_last", out_last, 1'b0);
            step();
        end
        @(negedge clk);
        check("t3_full_count", fifo_count, 3'd4);
        check("t3_full_ready", in_ready, 1'b0);
        drive_cmd(4'h6, 16'hC0DE, 76'h0FF);
        step();
        @(negedge clk);
        check("t3_stall_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("t3_b2_last", out_last, 1'b1);
        check("t3_b2_ready", in_ready, 1'b0);
        check("t3_b2_count", fifo_count, 3'd4);
        step();
        @(negedge clk);
        check("t6_after_pop_count", fifo_count, 3'd3);
        check("t6_after_pop_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_refill_count", fifo_count, 3'd4);
        repeat (25) step();
        check("t3_drained", out_valid, 1'b0);

        // 4: illegal shape dropped with one-cycle error pulse
        drive_cmd(4'hF, 16'hFFFF, 76'h1);
        @(negedge clk);
        check("t4_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_err_high", err_shape, 1'b1);
        check("t4_count", fifo_count, 3'd0);
        step();
        @(negedge clk);
        check("t4_err_low", err_shape, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("t4_no_beat", out_valid, 1'b0);
        end
        step();

        // 5: reset mid-packet
        out_ready = 1'b0;
        send_cmd(4'h1, 16'h1111, 76'h1);
        send_cmd(4'h2, 16'h2222, 76'h2);
        send_cmd(4'h3, 16'h3333, 76'h3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("t5_in_beat1", out_valid, 1'b1);
        check("t5_queued", fifo_count, 3'd2);
        #2 n_rst = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_count", fifo_count, 3'd0);
        check("t5_rst_data", out_data, 32'h0);
        check("t5_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        #2 n_rst = 1'b1;
        step();
        out_ready = 1'b1;
        drive_cmd(4'h6, 16'h0F0F, 76'h1);
        @(negedge clk);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_no_resume", out_valid, 1'b0);
        step();
        @(negedge clk);
        check("t5_new_first", out_first, 1'b1);
        check("t5_new_data", out_data, 32'h60F0F000);
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
